// File: rtl/pipe_is_chain.sv
// ---------------------------------------------------------------------------
// pipe_is_chain
//   Instruction-word shift chain for a 5-stage pipeline. It carries each
//   instruction word and its register-write enable from ID through EX, MEM
//   and WB. The forwarding/hazard unit decodes the per-stage outputs and
//   drives back the stall/clear controls.
//   It also keeps saturating hazard-event counters for the debug display.
//
// Ports
//   in_CLK        clock, all state changes on the rising edge
//   in_RST        synchronous active-high reset (wins over in_EN)
//   in_EN         global run enable; 0 freezes everything
//   in_IR         fetched instruction from IF
//   in_WE         write enable for the current ID instruction (out_IS)
//   in_PEN        pipeline enable; 0 = load-use stall
//   in_FDCLR      clear IF/ID (taken jump/branch); overrides a stall
//   in_DECLR      clear ID/EX (insert bubble)
//   out_IS/PIS/PPIS/PPPIS   ID/EX/MEM/WB instruction words
//   out_PWE/PPWE/PPPWE      EX/MEM/WB write enables
//   out_VLD       valid bits {WB,MEM,EX,ID}
//   out_STALLCNT  saturating count of stall cycles
//   out_BUBCNT    saturating count of bubbles loaded into EX
//   out_FLUSHCNT  saturating count of IF/ID flushes
// ---------------------------------------------------------------------------
module pipe_is_chain #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_EN,
  input  logic [31:0]      in_IR,
  input  logic             in_WE,
  input  logic             in_PEN,
  input  logic             in_FDCLR,
  input  logic             in_DECLR,
  output logic [31:0]      out_IS,
  output logic [31:0]      out_PIS,
  output logic [31:0]      out_PPIS,
  output logic [31:0]      out_PPPIS,
  output logic             out_PWE,
  output logic             out_PPWE,
  output logic             out_PPPWE,
  output logic [3:0]       out_VLD,
  output logic [CNT_W-1:0] out_STALLCNT,
  output logic [CNT_W-1:0] out_BUBCNT,
  output logic [CNT_W-1:0] out_FLUSHCNT
);

  // Stage registers
  logic [31:0] id_is_q,  id_is_d;
  logic [31:0] ex_is_q,  ex_is_d;
  logic [31:0] mem_is_q, mem_is_d;
  logic [31:0] wb_is_q,  wb_is_d;
  logic        ex_we_q,  ex_we_d;
  logic        mem_we_q, mem_we_d;
  logic        wb_we_q,  wb_we_d;
  logic [3:0]  vld_q,    vld_d;

  logic stall;
  logic bubble;

  always_comb begin
    stall  = ~in_PEN;
    bubble = in_DECLR | stall;

    // MEM and WB simply follow the stage in front of them.
    wb_is_d  = mem_is_q;
    wb_we_d  = mem_we_q;
    mem_is_d = ex_is_q;
    mem_we_d = ex_we_q;

    // EX: bubble, or take ID. Gating WE with the ID valid bit keeps a
    // cleared ID slot from ever producing a register write downstream.
    if (bubble) begin
      ex_is_d = NOP;
      ex_we_d = 1'b0;
    end else begin
      ex_is_d = id_is_q;
      ex_we_d = in_WE & vld_q[0];
    end

    // ID: a flush beats a stall so a taken branch is never held in ID.
    if (in_FDCLR) begin
      id_is_d = NOP;
    end else if (stall) begin
      id_is_d = id_is_q;
    end else begin
      id_is_d = in_IR;
    end

    vld_d[3] = vld_q[2];
    vld_d[2] = vld_q[1];
    vld_d[1] = bubble ? 1'b0 : vld_q[0];
    if (in_FDCLR) begin
      vld_d[0] = 1'b0;
    end else if (stall) begin
      vld_d[0] = vld_q[0];
    end else begin
      vld_d[0] = 1'b1;
    end
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      id_is_q  <= NOP;
      ex_is_q  <= NOP;
      mem_is_q <= NOP;
      wb_is_q  <= NOP;
      ex_we_q  <= 1'b0;
      mem_we_q <= 1'b0;
      wb_we_q  <= 1'b0;
      vld_q    <= 4'b0000;
    end else if (in_EN) begin
      id_is_q  <= id_is_d;
      ex_is_q  <= ex_is_d;
      mem_is_q <= mem_is_d;
      wb_is_q  <= wb_is_d;
      ex_we_q  <= ex_we_d;
      mem_we_q <= mem_we_d;
      wb_we_q  <= wb_we_d;
      vld_q    <= vld_d;
    end
  end

  // Hazard counters: index 0 = stall, 1 = bubble, 2 = flush.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [3];

  assign cnt_inc = {in_FDCLR, bubble, stall};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_d;

      // Saturate at all-ones instead of wrapping.
      always_comb begin
        cnt_d = cnt_q[gi];
        if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q[gi] + 1'b1;
        end
      end

      always_ff @(posedge in_CLK) begin
        if (in_RST) begin
          cnt_q[gi] <= '0;
        end else if (in_EN) begin
          cnt_q[gi] <= cnt_d;
        end
      end
    end
  endgenerate

  assign out_IS       = id_is_q;
  assign out_PIS      = ex_is_q;
  assign out_PPIS     = mem_is_q;
  assign out_PPPIS    = wb_is_q;
  assign out_PWE      = ex_we_q;
  assign out_PPWE     = mem_we_q;
  assign out_PPPWE    = wb_we_q;
  assign out_VLD      = vld_q;
  assign out_STALLCNT = cnt_q[0];
  assign out_BUBCNT   = cnt_q[1];
  assign out_FLUSHCNT = cnt_q[2];

endmodule

// File: tb/tb_pipe_is_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_is_chain
//   Directed test of pipe_is_chain. Two instances share all inputs: one with
//   the default 16-bit counters, one with 4-bit counters for saturation.
// ---------------------------------------------------------------------------
module tb_pipe_is_chain;

  logic        clk = 1'b0;
  logic        rst, en, we, pen, fdclr, declr;
  logic [31:0] ir;

  logic [31:0] is_o, pis_o, ppis_o, pppis_o;
  logic        pwe_o, ppwe_o, pppwe_o;
  logic [3:0]  vld_o;
  logic [15:0] stall_o, bub_o, flush_o;

  logic [31:0] s_is_o, s_pis_o, s_ppis_o, s_pppis_o;
  logic        s_pwe_o, s_ppwe_o, s_pppwe_o;
  logic [3:0]  s_vld_o;
  logic [3:0]  s_stall_o, s_bub_o, s_flush_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_is_chain dut (
    .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_IR(ir), .in_WE(we),
    .in_PEN(pen), .in_FDCLR(fdclr), .in_DECLR(declr),
    .out_IS(is_o), .out_PIS(pis_o), .out_PPIS(ppis_o), .out_PPPIS(pppis_o),
    .out_PWE(pwe_o), .out_PPWE(ppwe_o), .out_PPPWE(pppwe_o), .out_VLD(vld_o),
    .out_STALLCNT(stall_o), .out_BUBCNT(bub_o), .out_FLUSHCNT(flush_o)
  );

  pipe_is_chain #(.CNT_W(4)) dut_sat (
    .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_IR(ir), .in_WE(we),
    .in_PEN(pen), .in_FDCLR(fdclr), .in_DECLR(declr),
    .out_IS(s_is_o), .out_PIS(s_pis_o), .out_PPIS(s_ppis_o), .out_PPPIS(s_pppis_o),
    .out_PWE(s_pwe_o), .out_PPWE(s_ppwe_o), .out_PPPWE(s_pppwe_o), .out_VLD(s_vld_o),
    .out_STALLCNT(s_stall_o), .out_BUBCNT(s_bub_o), .out_FLUSHCNT(s_flush_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One edge; inputs change 1 time unit after it, outputs sampled there too.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stages(input string tag,
                              input logic [31:0] e_is, input logic [31:0] e_pis,
                              input logic [31:0] e_ppis, input logic [31:0] e_pppis,
                              input logic [2:0] e_we, input logic [3:0] e_vld);
    check_val({tag, ".IS"},    is_o,    e_is);
    check_val({tag, ".PIS"},   pis_o,   e_pis);
    check_val({tag, ".PPIS"},  ppis_o,  e_ppis);
    check_val({tag, ".PPPIS"}, pppis_o, e_pppis);
    check_val({tag, ".WE"},    {29'd0, pppwe_o, ppwe_o, pwe_o}, {29'd0, e_we});
    check_val({tag, ".VLD"},   {28'd0, vld_o}, {28'd0, e_vld});
  endtask

  task automatic check_cnts(input string tag, input int e_st, input int e_bu, input int e_fl);
    check_val({tag, ".STALL"}, {16'd0, stall_o}, e_st);
    check_val({tag, ".BUB"},   {16'd0, bub_o},   e_bu);
    check_val({tag, ".FLUSH"}, {16'd0, flush_o}, e_fl);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; pen = 1'b1; fdclr = 1'b0; declr = 1'b0;
    ir = 32'hFFFF_FFFF;

    // Reset
    step;
    check_stages("reset", 0, 0, 0, 0, 3'b000, 4'b0000);
    check_cnts("reset", 0, 0, 0);

    // Fill
    rst = 1'b0; en = 1'b1; we = 1'b1;
    ir = 32'h2008_0001; step;
    check_stages("fill1", 32'h2008_0001, 0, 0, 0, 3'b000, 4'b0001);
    ir = 32'h2009_0002; step;
    check_stages("fill2", 32'h2009_0002, 32'h2008_0001, 0, 0, 3'b001, 4'b0011);
    ir = 32'h0109_5020; step;
    ir = 32'h0000_0000; step;
    check_stages("fill4", 0, 32'h0109_5020, 32'h2009_0002, 32'h2008_0001, 3'b111, 4'b1111);
    check_cnts("fill4", 0, 0, 0);

    // Load-use stall
    ir = 32'h8C08_0000; step;
    ir = 32'h0109_5020; step;
    check_val("lu_pre.IS",  is_o,  32'h0109_5020);
    check_val("lu_pre.PIS", pis_o, 32'h8C08_0000);
    pen = 1'b0; ir = 32'hDEAD_BEEF; step;
    check_stages("lu_stall", 32'h0109_5020, 0, 32'h8C08_0000, 0, 3'b110, 4'b1101);
    check_cnts("lu_stall", 1, 1, 0);
    pen = 1'b1; ir = 32'h1234_5678; step;
    check_stages("lu_resume", 32'h1234_5678, 32'h0109_5020, 0, 32'h8C08_0000, 3'b101, 4'b1011);

    // Jump flush with bubble
    fdclr = 1'b1; declr = 1'b1; ir = 32'hAAAA_0000; step;
    check_stages("flush", 0, 0, 32'h0109_5020, 0, 3'b010, 4'b0100);
    check_cnts("flush", 1, 2, 1);
    fdclr = 1'b0; declr = 1'b0; ir = 32'h1111_1111; step;
    check_stages("post_flush", 32'h1111_1111, 0, 0, 32'h0109_5020, 3'b100, 4'b1001);

    // Freeze
    en = 1'b0; pen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ir = $urandom; fdclr = i[0]; declr = i[1];
      step;
    end
    check_stages("freeze", 32'h1111_1111, 0, 0, 32'h0109_5020, 3'b100, 4'b1001);
    check_cnts("freeze", 1, 2, 1);

    // Flush + bubble + stall together
    en = 1'b1; fdclr = 1'b1; declr = 1'b1; pen = 1'b0; ir = 32'h3333_3333; step;
    check_stages("all3", 0, 0, 0, 0, 3'b000, 4'b0000);
    check_cnts("all3", 2, 3, 2);

    // Saturation
    rst = 1'b1; step;
    rst = 1'b0; fdclr = 1'b0; declr = 1'b0; pen = 1'b0;
    repeat (20) step;
    check_val("sat.STALL4", {28'd0, s_stall_o}, 32'd15);
    check_val("sat.BUB4",   {28'd0, s_bub_o},   32'd15);
    check_val("sat.FLUSH4", {28'd0, s_flush_o}, 32'd0);
    check_cnts("sat.wide", 20, 20, 0);
    repeat (3) step;
    check_val("sat_hold.STALL4", {28'd0, s_stall_o}, 32'd15);
    check_val("sat_hold.BUB4",   {28'd0, s_bub_o},   32'd15);

    // DECLR alone: ID still advances, EX bubbled
    pen = 1'b1; declr = 1'b1; ir = 32'h2222_2222; step;
    check_val("declr.IS",  is_o,  32'h2222_2222);
    check_val("declr.PIS", pis_o, 32'h0000_0000);
    check_cnts("declr", 23, 24, 0);

    // Mid-run reset with pipeline full and EN low
    declr = 1'b0; we = 1'b1;
    ir = 32'h4000_0001; step;
    ir = 32'h4000_0002; step;
    ir = 32'h4000_0003; step;
    ir = 32'h4000_0004; step;
    check_stages("refill", 32'h4000_0004, 32'h4000_0003, 32'h4000_0002, 32'h4000_0001,
                 3'b111, 4'b1111);
    en = 1'b0; rst = 1'b1; step;
    check_stages("midrst", 0, 0, 0, 0, 3'b000, 4'b0000);
    check_cnts("midrst", 0, 0, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
